poly_result_collector: RTL and testbench

// - Downstream stage of the cubic-polynomial pipeline: captures each 13-bit y result the pipe produces (two per 6-clock frame).
// - Drops pipeline-fill warm-up results, tags each kept result with a sequence number and buffers it in a small FIFO.
// - Presents results to a consumer over a valid/ready handshake; reports overflow and dropped-result count.

---
 rtl/poly_result_collector_pkg.sv | 23 ++
 rtl/poly_result_collector_if.sv | 21 ++
 rtl/poly_result_collector_fifo.sv | 60 ++++++
 rtl/poly_result_collector.sv | 94 +++++++++
 tb/tb_poly_result_collector.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/poly_result_collector_pkg.sv
// Shared constants for the cubic-polynomial result collector.
// Holds result/tag widths, the pipeline frame geometry, default sample phases
// and warm-up length, plus the phase-advance helper used by the collector.
package poly_result_collector_pkg;

  localparam int Y_W        = 13;
  localparam int SEQ_W      = 8;
  localparam int DEPTH      = 4;
  localparam int FRAME_LEN  = 6;
  localparam int WARMUP_DEF = 4;
  localparam int SAMP_A_DEF = 2;
  localparam int SAMP_B_DEF = 5;
  localparam int DROP_W     = 8;

  localparam logic [2:0] PHASE_RESET = 3'd7;

  // 7 is the post-reset parking value; it and the last phase both lead to 0.
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    if (p == PHASE_RESET || p == 3'(FRAME_LEN - 1)) return 3'd0;
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/poly_result_collector_if.sv
// Result output bus of the collector.
// Handshake: out_valid is high whenever the head entry (out_data/out_seq) is
// meaningful; an entry transfers on a rising clock edge where out_valid and
// out_ready are both high. out_ready may be high while out_valid is low and is
// then ignored. out_data/out_seq are stable while out_valid is high and not
// accepted.
// Modports: master (collector side), slave (consumer side).
interface poly_result_collector_if #(
  parameter int Y_W   = poly_result_collector_pkg::Y_W,
  parameter int SEQ_W = poly_result_collector_pkg::SEQ_W
) ();

  logic             out_valid;
  logic             out_ready;
  logic [Y_W-1:0]   out_data;
  logic [SEQ_W-1:0] out_seq;

  modport master (output out_valid, output out_data, output out_seq, input out_ready);
  modport slave  (input out_valid, input out_data, input out_seq, output out_ready);

endinterface

// File: rtl/poly_result_collector_fifo.sv
// poly_sync_fifo: single-clock FIFO with asynchronous active-high reset.
// Ports: clock, reset; push/din write an entry (accepted when not full, or
// when a pop happens on the same edge); pop removes the head (ignored when
// empty); dout is the head entry, holding the last popped entry while empty;
// full, empty, level (entries held).
module poly_sync_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [W-1:0]  last_q;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // While empty the head keeps showing the entry that was popped last.
  assign dout = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/poly_result_collector.sv
// poly_result_collector: captures two y results per 6-clock pipeline frame,
// discards the warm-up results after reset, tags kept results with a wrapping
// sequence number and buffers them for a valid/ready consumer.
// Ports: clock, reset (async, active-high); enable gates sample capture;
// y is the pipeline result; out_if (master) carries out_valid/out_ready/
// out_data/out_seq; level = entries held; overflow is sticky on a lost
// sample; drop_count counts lost samples, saturating at 255.
module poly_result_collector
  import poly_result_collector_pkg::*;
#(
  parameter int Y_W    = poly_result_collector_pkg::Y_W,
  parameter int SEQ_W  = poly_result_collector_pkg::SEQ_W,
  parameter int DEPTH  = poly_result_collector_pkg::DEPTH,
  parameter int SAMP_A = SAMP_A_DEF,
  parameter int SAMP_B = SAMP_B_DEF,
  parameter int WARMUP = WARMUP_DEF,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [Y_W-1:0]                 y,
  poly_result_collector_if.master        out_if,
  output logic [LVL_W-1:0]               level,
  output logic                           overflow,
  output logic [DROP_W-1:0]              drop_count
);

  localparam int WARM_W = $clog2(WARMUP + 2);

  logic [2:0]         phase;
  logic [WARM_W-1:0]  warm;
  logic [SEQ_W-1:0]   seq;
  logic               slot;
  logic               warm_done;
  logic               pop;
  logic               push;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [Y_W+SEQ_W-1:0] head;

  // Phase value before the edge decides whether that edge is a sample slot.
  assign slot      = enable && (phase == 3'(SAMP_A) || phase == 3'(SAMP_B));
  assign warm_done = (warm == WARM_W'(WARMUP));
  assign pop       = out_if.out_valid && out_if.out_ready;
  // A same-edge pop frees a slot in a full FIFO, so only full-without-pop drops.
  assign drop      = slot && warm_done && fifo_full && !pop;
  assign push      = slot && warm_done && !drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase      <= PHASE_RESET;
      warm       <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      phase <= next_phase(phase);
      if (slot) begin
        if (!warm_done) begin
          warm <= warm + WARM_W'(1);
        end else begin
          // Tag advances on dropped samples too, so gaps in out_seq show loss.
          seq <= seq + SEQ_W'(1);
          if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
          end
        end
      end
    end
  end

  poly_sync_fifo #(
    .W     (Y_W + SEQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   ({y, seq}),
    .pop   (out_if.out_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = head[Y_W+SEQ_W-1:SEQ_W];
  assign out_if.out_seq   = head[SEQ_W-1:0];

endmodule

// File: tb/tb_poly_result_collector.sv
module tb_poly_result_collector;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [12:0] y = '0;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  logic [2:0] tb_phase;

  poly_result_collector_if bus ();

  poly_result_collector dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .y          (y),
    .out_if     (bus),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: bench phase model follows the frame, then sample at negedge.
  task automatic tick();
    @(posedge clock);
    tb_phase = (tb_phase == 3'd7 || tb_phase == 3'd5) ? 3'd0 : tb_phase + 3'd1;
    @(negedge clock);
  endtask

  task automatic to_slot();
    while (!(tb_phase == 3'd2 || tb_phase == 3'd5)) tick();
  endtask

  task automatic slot(input logic [12:0] v);
    to_slot();
    y = v;
    tick();
  endtask

  task automatic chk_head(input string tag, input logic [12:0] d, input logic [7:0] s,
                          input logic [2:0] lvl);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    chk({tag, "_seq"},   32'(bus.out_seq),   32'(s));
    chk({tag, "_level"}, 32'(level),         32'(lvl));
  endtask

  initial begin
    bus.out_ready = 1'b0;
    tb_phase = 3'd7;
    #2;
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_data",     32'(bus.out_data),  32'd0);
    chk("rst_seq",      32'(bus.out_seq),   32'd0);
    chk("rst_level",    32'(level),         32'd0);
    chk("rst_overflow", 32'(overflow),      32'd0);
    chk("rst_drop",     32'(drop_count),    32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Warm-up: 13 edges hold four slots, all discarded.
    enable = 1'b1;
    y = 13'd100;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("warmup_level", 32'(level), 32'd0);
    end
    chk("warmup_valid", 32'(bus.out_valid), 32'd0);

    // Pass-through with consumer ready.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      slot(13'(i));
      chk_head("pass", 13'(i), 8'(i - 1), 3'd1);
    end
    tick();
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_hold_data", 32'(bus.out_data), 32'd4);
    chk("empty_hold_seq", 32'(bus.out_seq), 32'd3);
    chk("empty_level", 32'(level), 32'd0);
    tick();
    chk("empty_ready_level", 32'(level), 32'd0);
    chk("empty_ready_data", 32'(bus.out_data), 32'd4);

    // One frame with enable low: no capture, seq frozen, phase keeps running.
    enable = 1'b0;
    repeat (6) tick();
    chk("dis_level", 32'(level), 32'd0);
    chk("dis_valid", 32'(bus.out_valid), 32'd0);
    enable = 1'b1;
    slot(13'd5);
    chk_head("reenable", 13'd5, 8'd4, 3'd1);
    bus.out_ready = 1'b0;

    // Fill to full without loss.
    slot(13'd6);
    chk("fill_level2", 32'(level), 32'd2);
    slot(13'd7);
    chk("fill_level3", 32'(level), 32'd3);
    slot(13'd8);
    chk_head("full", 13'd5, 8'd4, 3'd4);
    chk("full_overflow", 32'(overflow), 32'd0);

    // Full + slot + pop on the same edge: push accepted.
    to_slot();
    bus.out_ready = 1'b1;
    y = 13'd9;
    tick();
    bus.out_ready = 1'b0;
    chk_head("full_pop", 13'd6, 8'd5, 3'd4);
    chk("full_pop_overflow", 32'(overflow), 32'd0);
    chk("full_pop_drop", 32'(drop_count), 32'd0);

    // Overflow: 256 dropped slots; counter saturates, seq wraps back to 9.
    for (int k = 0; k < 256; k++) begin
      slot(13'h1abc);
      if (k == 1) begin
        chk("ovf_drop2", 32'(drop_count), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk_head("ovf_head", 13'd6, 8'd5, 3'd4);
      end
    end
    chk("ovf_drop_sat", 32'(drop_count), 32'd255);
    chk("ovf_flag_sticky", 32'(overflow), 32'd1);

    // Drain with enable low (pops still allowed).
    enable = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("drain", 13'(6 + i), 8'(5 + i), 3'(4 - i));
      tick();
    end
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_hold_seq", 32'(bus.out_seq), 32'd8);
    bus.out_ready = 1'b0;
    enable = 1'b1;

    // Next accepted entry: seq after 256 drops wrapped to 9.
    slot(13'h1fff);
    chk_head("after_ovf", 13'h1fff, 8'd9, 3'd1);
    slot(13'd31);
    slot(13'd32);
    chk("pre_rst_level", 32'(level), 32'd3);

    // Asynchronous reset mid-frame.
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_seq", 32'(bus.out_seq), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tb_phase = 3'd7;

    // Warm-up repeats, then seq restarts at 0.
    for (int i = 0; i < 4; i++) begin
      slot(13'd50);
      chk("rewarm_level", 32'(level), 32'd0);
    end
    slot(13'd51);
    chk_head("rewarm_first", 13'd51, 8'd0, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
